i2c_cmd_arbiter: RTL

//  Shares one i2c_master command/data port between NumReq requesters (Si570 ctrl, SFP/EEPROM readers, etc.).

---
 rtl/i2c_arb_pkg.sv | 31 +++
 rtl/i2c_arb_rr_pick.sv | 38 +++
 rtl/i2c_cmd_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared types for the I2C command arbiter: FSM states, command bit layout and
// the round-robin pointer wrap helper.
package i2c_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_OWN   = 2'd1,
        ARB_DRAIN = 2'd2
    } arb_state_e;

    localparam int CmdW               = 5;
    localparam int CMD_START          = 4;
    localparam int CMD_READ           = 3;
    localparam int CMD_WRITE          = 2;
    localparam int CMD_WRITE_MULTIPLE = 1;
    localparam int CMD_STOP           = 0;

    typedef struct packed {
        logic start;
        logic read;
        logic write;
        logic write_multiple;
        logic stop;
    } i2c_cmd_t;

    // Explicit wrap so non-power-of-two requester counts never point past the last lane.
    function automatic int rr_next(input int cur, input int n);
        return (cur >= n - 1) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/i2c_arb_rr_pick.sv
// Combinational round-robin pick: first set request at or after the pointer,
// wrapping back to lane 0. Outputs one-hot, index and an any-request flag.
module i2c_arb_rr_pick #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_onehot,
    output logic [PW-1:0] o_idx,
    output logic          o_any
);

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        // Wrapped half first (lanes below the pointer), then overwritten by the
        // preferred half; descending loops leave the lowest matching lane.
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i] && (i < int'(i_ptr))) begin
                o_onehot    = '0;
                o_onehot[i] = 1'b1;
                o_idx       = PW'(i);
                o_any       = 1'b1;
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i] && (i >= int'(i_ptr))) begin
                o_onehot    = '0;
                o_onehot[i] = 1'b1;
                o_idx       = PW'(i);
                o_any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Round-robin owner arbiter in front of a single i2c_master; ownership lasts from
// grant until STOP has completed on the bus. Optional idle-owner watchdog: I2C_ARB_TIMEOUT_EN.
module i2c_cmd_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NumReq        = 2,
    parameter int TimeoutCycles = 1000000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NumReq*7-1:0]    req_address,
    input  logic [NumReq*CmdW-1:0] req_cmd,
    input  logic [NumReq-1:0]      req_cmd_valid,
    output logic [NumReq-1:0]      req_cmd_ready,
    input  logic [NumReq*8-1:0]    req_data_in,
    input  logic [NumReq-1:0]      req_data_in_valid,
    input  logic [NumReq-1:0]      req_data_in_last,
    output logic [NumReq-1:0]      req_data_in_ready,
    output logic [7:0]             req_data_out,
    output logic [NumReq-1:0]      req_data_out_valid,
    output logic [NumReq-1:0]      req_missed_ack,
    output logic [NumReq-1:0]      grant,
    output logic                   timeout,
    output logic [6:0]             m_address,
    output logic [CmdW-1:0]        m_cmd,
    output logic                   m_cmd_valid,
    output logic [7:0]             m_data_in,
    output logic                   m_data_in_valid,
    output logic                   m_data_in_last,
    input  logic                   m_cmd_ready,
    input  logic                   m_data_in_ready,
    input  logic [7:0]             m_data_out,
    input  logic                   m_data_out_valid,
    input  logic                   m_missed_ack,
    input  logic                   m_busy
);

    localparam int PW = (NumReq > 1) ? $clog2(NumReq) : 1;

    if (NumReq < 2 || NumReq > 8) begin : g_bad_numreq
        $error("i2c_cmd_arbiter: NumReq must be 2..8");
    end
    if (TimeoutCycles < 2) begin : g_bad_timeout
        $error("i2c_cmd_arbiter: TimeoutCycles must be at least 2");
    end

    arb_state_e        r_state, w_state_next;
    logic [NumReq-1:0] r_grant;
    logic [PW-1:0]     r_owner, r_ptr, w_ptr_next;
    logic [NumReq-1:0] w_pick_onehot;
    logic [PW-1:0]     w_pick_idx;
    logic              w_pick_any, w_own, w_active;
    logic              w_cmd_hs, w_data_hs, w_stop_hs, w_release, w_wd_expire;
    i2c_cmd_t          w_owner_cmd;

    logic [6:0]      w_addr_lane [NumReq];
    logic [CmdW-1:0] w_cmd_lane  [NumReq];
    logic [7:0]      w_din_lane  [NumReq];

    generate
        for (genvar gi = 0; gi < NumReq; gi++) begin : g_lane
            assign w_addr_lane[gi]        = req_address[gi*7 +: 7];
            assign w_cmd_lane[gi]         = req_cmd[gi*CmdW +: CmdW];
            assign w_din_lane[gi]         = req_data_in[gi*8 +: 8];
            assign req_cmd_ready[gi]      = r_grant[gi] & w_own & m_cmd_ready;
            assign req_data_in_ready[gi]  = r_grant[gi] & m_data_in_ready;
            assign req_data_out_valid[gi] = r_grant[gi] & m_data_out_valid;
            assign req_missed_ack[gi]     = r_grant[gi] & m_missed_ack;
        end
    endgenerate

    i2c_arb_rr_pick #(.N(NumReq), .PW(PW)) u_pick (
        .i_req    (req_cmd_valid),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    assign w_own        = (r_state == ARB_OWN);
    assign w_active     = (r_state != ARB_IDLE);
    assign w_owner_cmd  = w_cmd_lane[r_owner];
    assign w_cmd_hs     = m_cmd_valid & m_cmd_ready;
    assign w_data_hs    = m_data_in_valid & m_data_in_ready;
    assign w_stop_hs    = w_cmd_hs & w_owner_cmd.stop;
    assign w_ptr_next   = PW'(rr_next(int'(r_owner), NumReq));
    assign w_release    = ((r_state == ARB_DRAIN) && !m_busy) || w_wd_expire;
    assign grant        = r_grant;
    assign req_data_out = m_data_out;

`ifdef I2C_ARB_TIMEOUT_EN
    logic [31:0] r_wd;
    logic        r_timeout;

    assign w_wd_expire = w_own & ~(w_cmd_hs | w_data_hs) & (r_wd == 32'(TimeoutCycles - 1));
    assign timeout     = r_timeout;

    // Only a silent owner counts; any handshake or leaving OWN restarts the window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wd      <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_wd_expire;
            if (!w_own || w_cmd_hs || w_data_hs) r_wd <= '0;
            else                                 r_wd <= r_wd + 32'd1;
        end
    end
`else
    assign w_wd_expire = 1'b0;
    assign timeout     = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ARB_IDLE;
            r_grant <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == ARB_IDLE) && w_pick_any) begin
                r_grant <= w_pick_onehot;
                r_owner <= w_pick_idx;
            end
            if (w_release) begin
                r_grant <= '0;
                r_ptr   <= w_ptr_next;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ARB_IDLE:  if (w_pick_any) w_state_next = ARB_OWN;
            ARB_OWN: begin
                if (w_stop_hs)        w_state_next = ARB_DRAIN;
                else if (w_wd_expire) w_state_next = ARB_IDLE;
            end
            ARB_DRAIN: if (!m_busy) w_state_next = ARB_IDLE;
            default:   w_state_next = ARB_IDLE;
        endcase
    end

    // DRAIN keeps the owner's data lanes connected while the STOP finishes.
    always_comb begin
        m_address       = '0;
        m_cmd           = '0;
        m_cmd_valid     = 1'b0;
        m_data_in       = '0;
        m_data_in_valid = 1'b0;
        m_data_in_last  = 1'b0;
        if (w_active) begin
            m_address       = w_addr_lane[r_owner];
            m_cmd           = w_cmd_lane[r_owner];
            m_cmd_valid     = w_own & req_cmd_valid[r_owner];
            m_data_in       = w_din_lane[r_owner];
            m_data_in_valid = req_data_in_valid[r_owner];
            m_data_in_last  = req_data_in_last[r_owner];
        end
    end

endmodule
